// File: rtl/cpu_pkg.sv
// Shared definitions for the simple-CPU sequencer: state codes, opcodes,
// bus source/destination codes and instruction field positions.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_LOAD   = 5'd1,
        S_MOV    = 5'd2,
        S_ARA    = 5'd3,
        S_ARG    = 5'd4,
        S_ARW    = 5'd5,
        S_FETCH  = 5'd6,
        S_DECODE = 5'd7,
        S_BRANCH = 5'd8,
        S_HALT   = 5'd9
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_BRZ  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [3:0] BUS_NONE = 4'd0;
    localparam logic [3:0] BUS_G    = 4'd9;
    localparam logic [3:0] BUS_IMM  = 4'd10;
    localparam logic [3:0] BUS_A    = 4'd10;
    localparam logic [3:0] BUS_MAX  = 4'd10;

    localparam int OP_MSB  = 22;
    localparam int OP_LSB  = 20;
    localparam int RD_MSB  = 19;
    localparam int RD_LSB  = 16;
    localparam int RS_MSB  = 15;
    localparam int RS_LSB  = 12;
    localparam int IMM_MSB = 11;
    localparam int IMM_LSB = 0;

    // Codes above the last defined bus slot must never reach the bus.
    function automatic logic [3:0] bus_code(input logic [3:0] c);
        return (c > BUS_MAX) ? BUS_NONE : c;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_seq_out_decode.sv
// Combinational bus-control decode: maps the current state and the
// instruction register fields to the bus source, destination and ALU op.
module seq_out_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] op,
    input  logic [3:0] rd,
    input  logic [3:0] rs,
    output logic [3:0] tribuf,
    output logic [3:0] r_en,
    output logic       alu_sub
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        tribuf  = BUS_NONE;
        r_en    = BUS_NONE;
        alu_sub = 1'b0;
        case (state)
            S_LOAD: begin
                tribuf = BUS_IMM;
                r_en   = bus_code(rd);
            end
            S_MOV: begin
                tribuf = bus_code(rs);
                r_en   = bus_code(rd);
            end
            S_ARA: begin
                tribuf = bus_code(rd);
                r_en   = BUS_A;
            end
            S_ARG: begin
                tribuf  = bus_code(rs);
                r_en    = BUS_G;
                alu_sub = (op == OP_SUB);
            end
            S_ARW: begin
                tribuf = BUS_G;
                r_en   = bus_code(rd);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch handshake, instruction register
// and the state machine that owns the shared bus and datapath strobes.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int IW = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          instr_req,
    input  logic          instr_valid,
    input  logic [IW-1:0] instr,
    input  logic          zero,
    output logic [4:0]    state,
    output logic [3:0]    tribuf,
    output logic [3:0]    r_en,
    output logic          alu_sub,
    output logic          PC_step,
    output logic          branch,
    output logic          done,
    output logic          err
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic          ir_load;
    logic [2:0]    op;
    logic          op_illegal;
    logic          unused_imm;

    assign op         = ir_q[OP_MSB:OP_LSB];
    assign op_illegal = !(op inside {OP_LOAD, OP_MOV, OP_ADD, OP_SUB, OP_BRZ, OP_HALT});
    // The immediate is routed to the PC/datapath outside this block.
    assign unused_imm = ^ir_q[IMM_MSB:IMM_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) ir_q <= instr;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: begin
                // An instruction arriving as run drops is still accepted.
                if (instr_valid) begin
                    state_d = S_DECODE;
                    ir_load = 1'b1;
                end else if (!run) begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:        state_d = S_LOAD;
                    OP_MOV:         state_d = S_MOV;
                    OP_ADD, OP_SUB: state_d = S_ARA;
                    OP_BRZ:         state_d = S_BRANCH;
                    OP_HALT:        state_d = S_HALT;
                    default:        state_d = run ? S_FETCH : S_IDLE;
                endcase
            end
            S_ARA:   state_d = S_ARG;
            S_ARG:   state_d = S_ARW;
            S_LOAD, S_MOV, S_ARW, S_BRANCH:
                     state_d = run ? S_FETCH : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    seq_out_decode u_out_decode (
        .state   (state_q),
        .op      (op),
        .rd      (ir_q[RD_MSB:RD_LSB]),
        .rs      (ir_q[RS_MSB:RS_LSB]),
        .tribuf  (tribuf),
        .r_en    (r_en),
        .alu_sub (alu_sub)
    );

    assign state     = state_q;
    assign instr_req = (state_q == S_FETCH);
    assign PC_step   = (state_q == S_FETCH) && instr_valid;
    assign branch    = (state_q == S_BRANCH) && zero;
    assign err       = (state_q == S_DECODE) && op_illegal;
    assign done      = (state_q inside {S_LOAD, S_MOV, S_ARW, S_BRANCH}) || err;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: an instruction-level model expands each
// accepted instruction into its expected per-cycle outputs, plus literal checks.
module tb_cpu_seq_ctrl;

    localparam int IW = 23;

    logic          clk = 1'b0;
    logic          rst_n, run, instr_valid, zero;
    logic [IW-1:0] instr;
    logic          instr_req, alu_sub, PC_step, branch, done, err;
    logic [4:0]    state;
    logic [3:0]    tribuf, r_en;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(.IW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .instr_req   (instr_req),
        .instr_valid (instr_valid),
        .instr       (instr),
        .zero        (zero),
        .state       (state),
        .tribuf      (tribuf),
        .r_en        (r_en),
        .alu_sub     (alu_sub),
        .PC_step     (PC_step),
        .branch      (branch),
        .done        (done),
        .err         (err)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: one record per expected cycle; st/tb/re are the spec's codes.
    typedef struct {
        int st;
        int tb;
        int re;
        bit sub;
        bit dn;
        bit er;
    } step_t;

    step_t cur = '{default: 0};
    step_t q[$];
    bit    halted = 1'b0;

    function automatic step_t mk(int st, int tb, int re, bit sub, bit dn, bit er);
        step_t s;
        s.st = st; s.tb = tb; s.re = re; s.sub = sub; s.dn = dn; s.er = er;
        return s;
    endfunction

    function automatic int code(int f);
        return (f > 10) ? 0 : f;
    endfunction

    function automatic void expand(logic [22:0] w);
        int op, rd, rs;
        op = int'(w[22:20]);
        rd = code(int'(w[19:16]));
        rs = code(int'(w[15:12]));
        case (op)
            0: begin q.push_back(mk(7, 0, 0, 0, 0, 0)); q.push_back(mk(1, 10, rd, 0, 1, 0)); end
            1: begin q.push_back(mk(7, 0, 0, 0, 0, 0)); q.push_back(mk(2, rs, rd, 0, 1, 0)); end
            2, 3: begin
                q.push_back(mk(7, 0, 0, 0, 0, 0));
                q.push_back(mk(3, rd, 10, 0, 0, 0));
                q.push_back(mk(4, rs, 9, op == 3, 0, 0));
                q.push_back(mk(5, 9, rd, 0, 1, 0));
            end
            4: begin q.push_back(mk(7, 0, 0, 0, 0, 0)); q.push_back(mk(8, 0, 0, 0, 1, 0)); end
            7: begin q.push_back(mk(7, 0, 0, 0, 0, 0)); q.push_back(mk(9, 0, 0, 0, 0, 0)); halted = 1'b1; end
            default: q.push_back(mk(7, 0, 0, 0, 1, 1));
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            halted = 1'b0;
            cur = mk(0, 0, 0, 0, 0, 0);
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (halted) begin
            cur = mk(9, 0, 0, 0, 0, 0);
        end else if (cur.st == 6 && instr_valid) begin
            expand(instr);
            cur = q.pop_front();
        end else begin
            cur = mk(run ? 6 : 0, 0, 0, 0, 0, 0);
        end
    end

    always @(negedge clk) begin
        logic [18:0] exp_v, act_v;
        exp_v = {5'(cur.st), cur.st == 6, 4'(cur.tb), 4'(cur.re), cur.sub,
                 (cur.st == 6) && instr_valid, (cur.st == 8) && zero, cur.dn, cur.er};
        act_v = {state, instr_req, tribuf, r_en, alu_sub, PC_step, branch, done, err};
        check($sformatf("outputs@%0t", $time), 32'(act_v), 32'(exp_v));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [22:0] w, input int waits);
        int n;
        n = 0;
        while (instr_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("fetch_req_seen", 32'(n < 40), 1);
        for (int i = 0; i < waits; i++) begin
            check("wait_state", state, 6);
            check("wait_req", instr_req, 1);
            check("wait_pc_step", PC_step, 0);
            tick();
        end
        instr       = w;
        instr_valid = 1'b1;
        #1 check("accept_pc_step", PC_step, 1);
        tick();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; zero = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_req", instr_req, 0);
        check("rst_bus", {tribuf, r_en}, 0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", state, 0);
        run = 1'b1;

        // LOAD R3 (code 4), imm 0x05A
        fetch({3'd0, 4'd4, 4'd0, 12'h05A}, 0);
        check("load_decode", state, 7);
        tick();
        check("load_state", state, 1);
        check("load_bus", {tribuf, r_en}, {4'd10, 4'd4});
        check("load_done", done, 1);
        tick();
        check("b2b_fetch", state, 6);

        // ADD rd=2, rs=5
        fetch({3'd2, 4'd2, 4'd5, 12'h000}, 0);
        tick(); check("ara_bus", {tribuf, r_en}, {4'd2, 4'd10});
        tick(); check("arg_bus", {tribuf, r_en, 3'b0, alu_sub}, {4'd5, 4'd9, 4'd0});
        tick(); check("arw_bus", {tribuf, r_en, 3'b0, done}, {4'd9, 4'd2, 4'd1});

        // SUB rd=7, rs=3
        fetch({3'd3, 4'd7, 4'd3, 12'h000}, 0);
        tick(); tick();
        check("sub_alu", alu_sub, 1);
        tick();
        check("sub_arw", {r_en, 3'b0, done}, {4'd7, 4'd1});

        // MOV rd=1, rs=8 after three wait cycles
        fetch({3'd1, 4'd1, 4'd8, 12'h000}, 3);
        tick();
        check("mov_bus", {state, tribuf, r_en}, {5'd2, 4'd8, 4'd1});

        // BRZ taken, then not taken
        zero = 1'b1;
        fetch({3'd4, 4'd0, 4'd0, 12'h010}, 0);
        tick();
        check("brz_taken", {branch, done}, 2'b11);
        tick();
        check("brz_one_cycle", branch, 0);
        zero = 1'b0;
        fetch({3'd4, 4'd0, 4'd0, 12'h020}, 0);
        tick();
        check("brz_not_taken", {branch, done}, 2'b01);

        // Out-of-range register codes never reach the bus
        fetch({3'd1, 4'd12, 4'd15, 12'h000}, 0);
        tick();
        check("mov_oob", {tribuf, r_en, 3'b0, done}, {4'd0, 4'd0, 4'd1});

        // Illegal opcode 5
        fetch({3'd5, 4'd3, 4'd3, 12'h000}, 0);
        check("ill_pulse", {err, done, tribuf, r_en}, {2'b11, 8'd0});
        tick();
        check("ill_refetch", state, 6);

        // Drop run during ARG: ARW still retires, then IDLE
        fetch({3'd2, 4'd1, 4'd2, 12'h000}, 0);
        tick(); tick();
        run = 1'b0;
        tick();
        check("drop_arw", {state, done}, {5'd5, 1'b1});
        tick();
        check("drop_idle", {state, instr_req}, {5'd0, 1'b0});

        // run falling together with instr_valid: still accepted
        run = 1'b1;
        tick();
        check("rv_fetch", instr_req, 1);
        run = 1'b0; instr = {3'd0, 4'd2, 4'd0, 12'h001}; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; instr = '0;
        check("rv_decode", state, 7);
        tick(); check("rv_load", state, 1);
        tick(); check("rv_idle", state, 0);

        // run falling in FETCH with no valid
        run = 1'b1;
        tick();
        check("rf_fetch", state, 6);
        run = 1'b0;
        tick();
        check("rf_idle", {state, instr_req}, {5'd0, 1'b0});

        // Reset asserted in ARA
        run = 1'b1;
        fetch({3'd2, 4'd3, 4'd4, 12'h000}, 0);
        tick();
        check("rst_ara_pre", state, 3);
        #2 rst_n = 1'b0;
        #1 check("rst_ara_outs", {state, instr_req, tribuf, r_en, alu_sub, done, err}, 0);
        tick();
        rst_n = 1'b1;

        // HALT sticks until reset
        fetch({3'd7, 4'd0, 4'd0, 12'h000}, 0);
        tick();
        check("halt_state", state, 9);
        repeat (3) tick();
        check("halt_stay", {state, instr_req, done}, {5'd9, 2'b00});
        rst_n = 1'b0;
        #1 check("halt_reset", state, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle instruction sequencer for the shared-bus simple CPU. Fetches a 23-bit instruction through a request/valid handshake, holds it in an internal instruction register, and steps a state machine that drives the bus tri-state source select, the register write enables, the ALU operation, the PC increment and the branch strobe. It sits between the instruction memory port and the register file, ALU and PC datapath, and is the sole owner of the shared bus.

## Interface
- `IW`, default 23: instruction width (field positions below are fixed for 23).
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `run`  in  1: level; high lets the sequencer fetch and execute continuously.
- `instr_req`  out  1: instruction fetch request.
- `instr_valid`  in  1: instruction present on `instr` this cycle.
- `instr`  in  IW: op = [22:20], rd = [19:16], rs = [15:12], imm = [11:0].
- `zero`  in  1: ALU zero flag, sampled in BRANCH.
- `state`  out  5: current state code.
- `tribuf`  out  4: bus source. 0 = none, 1–8 = R0–R7, 9 = G, 10 = IMM.
- `r_en`  out  4: bus destination. 0 = none, 1–8 = R0–R7, 9 = G, 10 = A.
- `alu_sub`  out  1: 0 = add, 1 = subtract.
- `PC_step`  out  1: PC increment strobe.
- `branch`  out  1: PC load-from-imm strobe.
- `done`  out  1: instruction-retired pulse.
- `err`  out  1: illegal-opcode pulse.

## Operation
- States and codes:
  - IDLE = 0
  - LOAD = 1
  - MOV = 2
  - ARA = 3
  - ARG = 4
  - ARW = 5
  - FETCH = 6
  - DECODE = 7
  - BRANCH = 8
  - HALT = 9
- Opcodes: 0 LOAD, 1 MOV, 2 ADD, 3 SUB, 4 BRZ, 7 HALT. Opcodes 5 and 6 are illegal.
- IDLE: when `run` = 1, go to FETCH.
- FETCH: `instr_req` = 1 every cycle in this state. When `instr_valid` = 1, latch IR, pulse `PC_step`, go to DECODE. Otherwise stay.
- DECODE: branch on IR op to LOAD, MOV, ARA, BRANCH or HALT.
  - Illegal op: pulse `err` and `done`, then go to FETCH (or IDLE if `run` = 0).
- LOAD: `tribuf` = 10, `r_en` = rd.
- MOV: `tribuf` = rs, `r_en` = rd.
- ARA: `tribuf` = rd, `r_en` = 10.
- ARG: `tribuf` = rs, `r_en` = 9, `alu_sub` = (op == SUB).
- ARW: `tribuf` = 9, `r_en` = rd.
- BRANCH: `branch` = `zero`.
- HALT: stay in HALT until reset. All strobes are 0.
- Retire: LOAD, MOV, ARW and BRANCH pulse `done`, then go to FETCH if `run` = 1, else IDLE.
- `run` falling mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- `run` falling while in FETCH with no valid yet: go to IDLE and drop `instr_req`.
- `run` = 0 and `instr_valid` = 1 in the same FETCH cycle: the instruction is accepted.
- Any state, `tribuf`, or `r_en` code outside the lists above: drive 0 on the bus controls.

## Timing
- All outputs are Moore functions of the registered state and IR. None depend combinationally on inputs, except:
  - `PC_step` = FETCH & `instr_valid`
  - `branch` = BRANCH & `zero`
- Reset (asynchronous assert, synchronous release): state = IDLE, IR = 0, all outputs 0.
- Reset mid-instruction aborts immediately. No partial-write protection.
- Cycles from `instr_valid` to `done`, counting the DECODE cycle as 1:
  - LOAD, MOV, BRZ: 2.
  - ADD, SUB: 4.
- Back-to-back issue: the next FETCH begins the cycle after the retire state.
- With zero-wait memory, throughput is 3 cycles per LOAD/MOV/BRZ and 5 per ADD/SUB.
- `tribuf` is never nonzero outside LOAD, MOV, ARA, ARG and ARW. This guarantees a single bus driver.

## Structure
- `cpu_pkg` holds:
  - state code localparams
  - opcode constants
  - bus source and destination codes: `BUS_NONE`, `BUS_G` = 9, `BUS_IMM`/`BUS_A` = 10
  - the instruction field bit ranges
- One sub-module, `seq_out_decode`: purely combinational; maps {state, IR} to `tribuf`, `r_en` and `alu_sub`.
- The FSM, IR and strobes live in `cpu_seq_ctrl`.

## Test plan
- LOAD R3, imm 0x05A: `instr_valid` at cycle t. Expect `PC_step` at t, LOAD at t+2 with `tribuf` = 10 and `r_en` = 4, `done` at t+2.
- ADD rd = 2, rs = 5: ARA with `tribuf` = 2 / `r_en` = 10, then ARG with 5 / 9 and `alu_sub` = 0, then ARW with 9 / 2. `done` 4 cycles after accept. SUB identical except `alu_sub` = 1.
- BRZ with `zero` = 1, then `zero` = 0: expect `branch` = 1 for exactly one cycle, then 0. `done` is pulsed in both cases.
- `instr_valid` held low for 3 FETCH cycles: `instr_req` stays high, state stays 6, no strobes. Accept occurs on the 4th cycle.
- Opcode 5: `err` and `done` pulse in DECODE, no bus activity, FSM returns to FETCH.
- Drop `run` during ARG: ARW still executes, `done` pulses, then the FSM goes to IDLE. Assert `rst_n` = 0 in ARA: all outputs are 0 that cycle.
